// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The state encoding is fixed because it also appears in the global defines.
package fetch_ctrl_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_FULL = 2'd3
    } fc_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Output register toward ID plus a one-entry skid slot.
// Flush has priority over every other control.
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         skid_load,
    input  logic         shift,
    input  logic         consume,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] in_pc,
    output logic [W-1:0] inst_out,
    output logic [W-1:0] inst_pc,
    output logic         inst_valid,
    output logic         skid_valid
);

    logic [W-1:0] skid_data;
    logic [W-1:0] skid_pc;

    // A consumed slot is zeroed so ID always sees a nop while inst_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            inst_out   <= '0;
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (shift) begin
                inst_out   <= skid_data;
                inst_pc    <= skid_pc;
                inst_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (load) begin
                inst_out   <= in_data;
                inst_pc    <= in_pc;
                inst_valid <= 1'b1;
            end else if (consume) begin
                inst_out   <= '0;
                inst_valid <= 1'b0;
            end
            if (skid_load) begin
                skid_data  <= in_data;
                skid_pc    <= in_pc;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues one memory request per PC, stalls the PC until it
// completes, and drops wrong-path data after a branch redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc_in,
    input  logic         redirect,
    output logic         pc_stall,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_rdata,
    input  logic         id_ready,
    output logic [W-1:0] inst_out,
    output logic [W-1:0] inst_pc,
    output logic         inst_valid
);

    fc_state_e    state, state_next;
    logic [W-1:0] addr_q;
    logic         buf_load, skid_load, buf_shift, buf_flush;
    logic         skid_valid;
    logic         slot_free;

    // addr_q keeps the in-flight address once the PC has moved to a branch target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_REQ) begin
                addr_q <= pc_in;
            end
        end
    end

    assign slot_free = !inst_valid || id_ready;

    always_comb begin
        state_next = state;
        buf_load   = 1'b0;
        skid_load  = 1'b0;
        buf_shift  = 1'b0;
        buf_flush  = redirect;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (redirect) begin
                    state_next = imem_ack ? S_REQ : S_DROP;
                end else if (imem_ack) begin
                    if (slot_free) begin
                        buf_load = 1'b1;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = S_FULL;
                    end
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_next = S_REQ;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    state_next = S_REQ;
                end else if (id_ready) begin
                    buf_shift  = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign imem_req  = (state == S_REQ) || (state == S_DROP);
    assign imem_addr = (state == S_DROP) ? addr_q : pc_in;
    assign pc_stall  = !(redirect || ((state == S_REQ) && imem_ack));

    fetch_buf #(.W(W)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .skid_load  (skid_load),
        .shift      (buf_shift),
        .consume    (inst_valid && id_ready),
        .flush      (buf_flush),
        .in_data    (imem_rdata),
        .in_pc      (pc_in),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .skid_valid (skid_valid)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and wait-state memory models around the DUT,
// with a scoreboard of accepted fetches checked in order as ID consumes them.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int W = WORD_WIDTH;

    typedef struct {
        logic [W-1:0] inst;
        logic [W-1:0] pc;
    } sb_item_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pc_in;
    logic         redirect = 1'b0;
    logic         pc_stall;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_rdata;
    logic         id_ready = 1'b1;
    logic [W-1:0] inst_out;
    logic [W-1:0] inst_pc;
    logic         inst_valid;

    logic [W-1:0] pc_rst_val = '0;
    logic [W-1:0] target = '0;
    int           wait_cfg = 0;
    int           wait_cnt = 0;
    logic         wrong_path = 1'b0;

    int checks = 0;
    int errors = 0;

    sb_item_t sb[$];
    sb_item_t item;
    logic         prev_live = 1'b0;
    logic         prev_accept = 1'b0;
    logic         prev_slot_free = 1'b0;
    logic         prev_redirect = 1'b0;
    logic         prev_req = 1'b0;
    logic         prev_ack = 1'b0;
    logic [W-1:0] prev_addr = '0;
    logic [W-1:0] prev_data = '0;
    logic         accept_now;

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .redirect   (redirect),
        .pc_stall   (pc_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_ready   (id_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] inst_of(input logic [W-1:0] addr);
        return addr ^ 32'hDEAD_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [W-1:0] tgt, input logic ready);
        @(posedge clk);
        #1;
        redirect = redir;
        target   = tgt;
        id_ready = ready;
        @(negedge clk);
    endtask

    task automatic doReset(input logic [W-1:0] pcv);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        redirect   = 1'b0;
        pc_rst_val = pcv;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitReq(input int max_cycles);
        int n = 0;
        while (!imem_req && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_seen", imem_req, 1'b1);
    endtask

    // PC register: holds on stall, loads the branch target on redirect.
    always @(posedge clk) begin
        if (rst) pc_in <= pc_rst_val;
        else if (!pc_stall) pc_in <= redirect ? target : pc_in + 4;
    end

    // Memory acks after wait_cfg cycles of a held request.
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = !rst && imem_req && (wait_cnt == wait_cfg);
    assign imem_rdata = inst_of(imem_addr);

    // Marks an outstanding request that was issued before a redirect.
    always @(posedge clk) begin
        if (rst) wrong_path <= 1'b0;
        else if (imem_ack) wrong_path <= 1'b0;
        else if (redirect && imem_req) wrong_path <= 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_live = 1'b0;
        end else begin
            if (prev_live) begin
                if (prev_accept && prev_slot_free) begin
                    checkOutput("lat_valid", inst_valid, 1'b1);
                    checkOutput("lat_pc", inst_pc, prev_addr);
                    checkOutput("lat_data", inst_out, prev_data);
                end
                if (prev_accept && !prev_slot_free) checkOutput("full_req", imem_req, 1'b0);
                if (prev_redirect) begin
                    checkOutput("flush_valid", inst_valid, 1'b0);
                    checkOutput("flush_out", inst_out, ZERO_WORD);
                end
                if (prev_req && !prev_ack) begin
                    checkOutput("req_held", imem_req, 1'b1);
                    checkOutput("addr_stable", imem_addr, prev_addr);
                end
            end
            checkOutput("skid_inv", dut.u_buf.skid_valid, dut.state == S_FULL);
            accept_now = imem_ack && !redirect && !wrong_path;
            checkOutput("pc_stall", pc_stall, !(redirect || accept_now));
            if (inst_valid && id_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected", inst_valid, 1'b0);
                end else begin
                    item = sb.pop_front();
                    checkOutput("sb_pc", inst_pc, item.pc);
                    checkOutput("sb_inst", inst_out, item.inst);
                end
            end
            if (redirect) sb.delete();
            else if (accept_now) sb.push_back('{inst: imem_rdata, pc: imem_addr});
            prev_accept    = accept_now;
            prev_slot_free = !inst_valid || id_ready;
            prev_redirect  = redirect;
            prev_req       = imem_req;
            prev_ack       = imem_ack;
            prev_addr      = imem_addr;
            prev_data      = imem_rdata;
            prev_live      = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_req", imem_req, 1'b0);
        checkOutput("rst_stall", pc_stall, 1'b1);
        checkOutput("rst_valid", inst_valid, 1'b0);
        checkOutput("rst_out", inst_out, ZERO_WORD);
        checkOutput("rst_pc", inst_pc, ZERO_WORD);

        // Zero-wait stream with ID always ready.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stream_valid", inst_valid, 1'b1);
        checkOutput("stream_pc", inst_pc, pc_in - 4);

        // Three wait states at 0x10.
        wait_cfg = 3;
        doReset(32'h10);
        waitReq(5);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ws_addr", imem_addr, 32'h10);
            checkOutput("ws_stall", pc_stall, 1'b1);
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("ws_ack_stall", pc_stall, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("ws_valid", inst_valid, 1'b1);
        checkOutput("ws_pc", inst_pc, 32'h10);

        // Backpressure fills the skid slot.
        wait_cfg = 0;
        id_ready = 1'b0;
        doReset(32'h20);
        waitReq(5);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("bp_state", dut.state, S_FULL);
        checkOutput("bp_req", imem_req, 1'b0);
        checkOutput("bp_stall", pc_stall, 1'b1);
        checkOutput("bp_pc0", inst_pc, 32'h20);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("bp_pc0_hold", inst_pc, 32'h20);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("bp_pc1", inst_pc, 32'h24);
        checkOutput("bp_back_req", imem_req, 1'b1);

        // Redirect while a request waits on memory.
        wait_cfg = 3;
        doReset(32'h30);
        waitReq(5);
        applyStimulus(1'b1, 32'h100, 1'b1);
        checkOutput("rd_addr1", imem_addr, 32'h30);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rd_drop_state", dut.state, S_DROP);
        checkOutput("rd_addr2", imem_addr, 32'h30);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rd_addr3", imem_addr, 32'h30);
        checkOutput("rd_ack_stall", pc_stall, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rd_valid", inst_valid, 1'b0);
        checkOutput("rd_new_addr", imem_addr, 32'h100);
        checkOutput("rd_new_req", imem_req, 1'b1);

        // Redirect in the same cycle as an ack.
        wait_cfg = 0;
        doReset(32'h40);
        waitReq(5);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("ra_valid", inst_valid, 1'b0);
        checkOutput("ra_out", inst_out, ZERO_WORD);
        checkOutput("ra_addr", imem_addr, 32'h200);

        // Redirect while the skid slot is full.
        id_ready = 1'b0;
        doReset(32'h50);
        waitReq(5);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rf_full", dut.state, S_FULL);
        applyStimulus(1'b1, 32'h300, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rf_valid", inst_valid, 1'b0);
        checkOutput("rf_skid", dut.u_buf.skid_valid, 1'b0);
        checkOutput("rf_out", inst_out, ZERO_WORD);
        checkOutput("rf_state", dut.state, S_REQ);
        checkOutput("rf_addr", imem_addr, 32'h300);

        // Reset while dropping a wrong-path request.
        wait_cfg = 6;
        id_ready = 1'b1;
        doReset(32'h60);
        waitReq(5);
        applyStimulus(1'b1, 32'h400, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rs_drop", dut.state, S_DROP);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        pc_rst_val = '0;
        wait_cfg   = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rs_req", imem_req, 1'b0);
        checkOutput("rs_stall", pc_stall, 1'b1);
        checkOutput("rs_valid", inst_valid, 1'b0);
        waitReq(5);
        checkOutput("rs_addr", imem_addr, ZERO_WORD);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rs_inst_valid", inst_valid, 1'b1);
        checkOutput("rs_inst_pc", inst_pc, ZERO_WORD);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC register and the instruction-memory bus. Issues a fetch for the current PC and holds the PC stalled until the fetch completes. Buffers returned instructions toward ID (output register plus one-entry skid). On a branch redirect it flushes wrong-path fetches, including a bus request that is still outstanding.

Parameters:
W, `WORD_WIDTH (32), width of addresses and instruction words

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pc_in  input  W  current PC from the PC register
redirect  input  1  branch taken (can_branch && branch_take); PC loads target at next edge
pc_stall  output  1  1 = PC holds; 0 = PC updates at next edge
imem_req  output  1  fetch request; held high with stable addr until imem_ack
imem_addr  output  W  fetch address
imem_ack  input  1  single-cycle completion; imem_rdata valid same cycle
imem_rdata  input  W  fetched instruction
id_ready  input  1  ID accepts inst_out this cycle
inst_out  output  W  instruction to ID; `ZERO_WORD (nop) when invalid
inst_pc  output  W  address of inst_out
inst_valid  output  1  inst_out valid

Behaviour:
- States: S_IDLE, S_REQ, S_DROP, S_FULL; 2-bit registered state.
- Reset values: state S_IDLE, inst_out, inst_pc, addr_q and skid = `ZERO_WORD, inst_valid 0, skid_valid 0.
- Reset outputs: imem_req 0, pc_stall 1.
- Reset mid-transaction abandons the outstanding request; imem shares rst.
- imem_req = (state==S_REQ || state==S_DROP).
- imem_addr = addr_q in S_DROP, otherwise pc_in.
- addr_q <= pc_in every cycle in S_REQ.
- pc_stall = 0 only when redirect=1 (any state), or when in S_REQ with imem_ack=1. Otherwise 1.
- Consumption: inst_valid && id_ready at an edge removes inst_out.
- S_IDLE: req 0; always goes to S_REQ next cycle.
- S_REQ, no ack, no redirect: stay.
- S_REQ, redirect && !ack: go to S_DROP; flush.
- S_REQ, redirect && ack: stay in S_REQ; discard rdata; flush.
- S_REQ, ack && !redirect, output slot free (!inst_valid || id_ready): inst_out <= imem_rdata, inst_pc <= pc_in, inst_valid <= 1; stay in S_REQ. Zero-wait memory gives 1 instruction/cycle.
- S_REQ, ack && !redirect, output occupied and !id_ready: skid <= {rdata, pc_in}, skid_valid <= 1; go to S_FULL.
- S_DROP: req stays high at addr_q. On ack go to S_REQ and discard rdata. A redirect in S_DROP gives pc_stall 0 and is otherwise a no-op (already flushing).
- S_FULL: req 0.
  - id_ready && !redirect: inst_out <= skid, skid_valid <= 0; go to S_REQ.
  - redirect: flush; go to S_REQ.
- Flush: inst_valid <= 0, inst_out <= `ZERO_WORD, skid_valid <= 0. Redirect beats ack and id_ready in the same cycle.
- Invariant: skid_valid == (state==S_FULL). The bench asserts it.
- Invariant: imem_addr is stable while imem_req is high and no ack has been received. The bench asserts it.
- Latency: ack at cycle N gives inst_valid at N+1. First request is issued the cycle after rst deasserts.

Decomposition:
- Add to defines.v: state encodings FC_S_IDLE=2'd0, FC_S_REQ=2'd1, FC_S_DROP=2'd2, FC_S_FULL=2'd3.
- `ZERO_WORD and `WORD_WIDTH are reused.
- One natural sub-module: fetch_buf, the output register plus skid with load/shift/flush controls. The FSM stays in fetch_ctrl.

Test Plan:
- Zero-wait stream: ack every REQ cycle, id_ready=1, pc 0,4,8 -> inst_valid from cycle 2; inst_pc 0,4,8 consecutive; pc_stall 0 each ack cycle.
- Wait states: ack 3 cycles after req at pc=0x10 -> imem_addr=0x10 and pc_stall=1 held 3 cycles; inst_pc=0x10 one cycle after ack.
- Backpressure: id_ready=0, two acks (0x20, 0x24) -> second goes to skid, state FULL, req 0. Then id_ready=1 -> inst_pc 0x20 then 0x24, back to REQ.
- Redirect during wait: req at 0x30, redirect at cycle 1, ack at cycle 3 -> imem_addr stays 0x30 through ack; rdata discarded; inst_valid 0; next req uses new pc_in (target 0x100).
- Redirect with ack same cycle and in FULL -> data dropped; inst_valid 0; skid_valid 0; inst_out 0; state REQ next cycle.
- Reset asserted in S_DROP -> next cycle req 0, pc_stall 1, inst_valid 0; fetch restarts from pc_in=0.
